// File: rtl/peripheral_mult_seq.sv
// Memory-mapped sequential unsigned multiplier for the FemtoRV32 data bus.
// The CPU loads A and B, writes START, polls STATUS, then reads the 2*WIDTH-bit product.
module peripheral_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    input  logic             cs,
    input  logic [4:0]       addr,
    input  logic             rd,
    input  logic             wr,
    output logic [31:0]      d_out
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [4:0] ADDR_A      = 5'h00;
    localparam logic [4:0] ADDR_B      = 5'h04;
    localparam logic [4:0] ADDR_START  = 5'h08;
    localparam logic [4:0] ADDR_STATUS = 5'h0C;
    localparam logic [4:0] ADDR_RESULT = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      d_out_q, d_out_d;

    logic             wr_en;
    logic             rd_en;
    logic             start;
    logic [PW-1:0]    acc_sum;

    assign wr_en = cs & wr;
    assign rd_en = cs & rd;
    assign start = wr_en && (addr == ADDR_START) && d_in[0];
    assign d_out = d_out_q;

    // Operand registers are frozen while a multiply is running.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (wr_en && (state_q != ST_BUSY)) begin
            if (addr == ADDR_A) a_d = d_in;
            if (addr == ADDR_B) b_d = d_in;
        end
    end

    // NOTE: every signal driven here gets its hold value first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        acc_sum  = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_d = {{WIDTH{1'b0}}, a_q};
                    mplr_d  = b_q;
                    acc_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                // The last bit's partial product is folded into RESULT on the same edge.
                if (cnt_q == CNT_LAST) begin
                    result_d = acc_sum;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is registered and holds until the next selected read.
    always_comb begin
        d_out_d = d_out_q;
        if (rd_en) begin
            case (addr)
                ADDR_STATUS: d_out_d = {30'b0, busy_q, done_q};
                ADDR_RESULT: d_out_d = 32'(result_q);
                default:     d_out_d = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            d_out_q  <= d_out_d;
        end
    end

endmodule

// File: tb/tb_peripheral_mult_seq.sv
// Self-checking bench for peripheral_mult_seq: directed vector table, hand sequences for
// busy/reset/unmapped corners, and random bus traffic against a cycle-timeline model.
module tb_peripheral_mult_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs, rd, wr;
    logic [4:0]    addr;
    logic [W-1:0]  d_in;
    logic [31:0]   d_out;

    int unsigned   cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    peripheral_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a timeline of accepted START edges and plain-arithmetic products.
    logic [31:0] m_a, m_b, m_res, m_pend, m_dout;
    bit          m_active;
    longint      m_start;

    function automatic bit m_busy(longint e);
        return m_active && (e > m_start) && (e <= m_start + W);
    endfunction

    function automatic bit m_fin(longint e);
        return m_active && (e > m_start + W);
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] a, longint e);
        case (a)
            5'h0C:   return m_busy(e) ? 32'h2 : (m_fin(e) ? 32'h1 : 32'h0);
            5'h10:   return m_fin(e) ? m_pend : m_res;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [4:0] a, input logic [W-1:0] data, input longint e);
        if (m_busy(e)) return;
        case (a)
            5'h00: m_a = 32'(data);
            5'h04: m_b = 32'(data);
            5'h08: begin
                if (data[0]) begin
                    if (m_fin(e)) m_res = m_pend;
                    m_pend   = m_a * m_b;
                    m_start  = e;
                    m_active = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic m_reset();
        m_a = 0; m_b = 0; m_res = 0; m_pend = 0; m_dout = 0;
        m_active = 1'b0;
        m_start = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One bus cycle; inputs change 1ns after the edge, d_out is sampled 1ns after the edge.
    task automatic access(input logic c, input logic r, input logic w, input logic [4:0] a,
                          input logic [W-1:0] data, input string name);
        longint e;
        cs = c; rd = r; wr = w; addr = a; d_in = data;
        @(posedge clk); #1;
        e = cyc;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        if (c && r) m_dout = m_read(a, e);
        if (c && w) m_write(a, data, e);
        check(name, d_out, m_dout);
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [W-1:0] data);
        access(1'b1, 1'b0, 1'b1, a, data, "write_hold");
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
        access(1'b1, 1'b1, 1'b0, a, '0, "read");
        v = d_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        wr_reg(5'h00, a);
        wr_reg(5'h04, b);
        wr_reg(5'h08, 16'h0001);
    endtask

    task automatic wait_done(output int nb);
        logic [31:0] v;
        bit got;
        got = 1'b0;
        nb = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            rd_reg(5'h0C, v);
            if (v == 32'h1) got = 1'b1;
            else if (v == 32'h2) nb++;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL wait_done: done not seen within 64 polls (busy reads %0d)", nb);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_reset();
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [31:0]  prod;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] v;
        int          nb;

        vecs[0] = '{a: 16'h0003, b: 16'h0005, prod: 32'h0000_000F};
        vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, prod: 32'hFFFE_0001};
        vecs[2] = '{a: 16'h0000, b: 16'h1234, prod: 32'h0000_0000};
        vecs[3] = '{a: 16'h00FF, b: 16'h0100, prod: 32'h0000_FF00};
        vecs[4] = '{a: 16'h8000, b: 16'h0002, prod: 32'h0001_0000};
        vecs[5] = '{a: 16'h0001, b: 16'h0001, prod: 32'h0000_0001};
        vecs[6] = '{a: 16'h1234, b: 16'h5678, prod: 32'h0626_0060};

        reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        m_reset();
        idle(2);
        reset = 1'b0;
        m_reset();

        // Reset state
        check("reset_dout", d_out, 32'h0);
        rd_reg(5'h0C, v); check("reset_status", v, 32'h0);
        rd_reg(5'h10, v); check("reset_result", v, 32'h0);

        // Vector table: latency and product
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(nb);
            check("latency", 32'(nb), 32'(W));
            rd_reg(5'h10, v);
            check("table_result", v, vecs[i].prod);
        end

        // Writes and START during BUSY are ignored
        start_op(16'd7, 16'd9);
        idle(1);
        wr_reg(5'h00, 16'd2);
        wr_reg(5'h04, 16'd2);
        wr_reg(5'h08, 16'h0001);
        wait_done(nb);
        rd_reg(5'h10, v); check("busy_ignore_result", v, 32'h3F);
        wr_reg(5'h08, 16'h0001);
        wait_done(nb);
        check("restart_latency", 32'(nb), 32'(W));
        rd_reg(5'h10, v); check("restart_result", v, 32'h3F);

        // RESULT read while busy returns the previous product
        start_op(16'd6, 16'd7);
        wait_done(nb);
        rd_reg(5'h10, v); check("result_6x7", v, 32'h2A);
        start_op(16'd100, 16'd100);
        idle(3);
        rd_reg(5'h10, v); check("result_midop", v, 32'h2A);
        wait_done(nb);
        rd_reg(5'h10, v); check("result_100x100", v, 32'h2710);

        // START with d_in[0]=0 does nothing
        wr_reg(5'h08, 16'hFFFE);
        rd_reg(5'h0C, v); check("start_bit0_clear", v, 32'h1);

        // Reset in the middle of an operation
        start_op(16'h00FF, 16'h0100);
        idle(4);
        pulse_reset();
        check("midreset_dout", d_out, 32'h0);
        rd_reg(5'h0C, v); check("midreset_status", v, 32'h0);
        rd_reg(5'h10, v); check("midreset_result", v, 32'h0);
        start_op(16'd2, 16'd3);
        wait_done(nb);
        rd_reg(5'h10, v); check("after_reset_2x3", v, 32'h6);

        // Unmapped accesses and cs=0 traffic
        rd_reg(5'h14, v); check("unmapped_read", v, 32'h0);
        wr_reg(5'h18, 16'hFFFF);
        start_op(16'd4, 16'd4);
        wait_done(nb);
        rd_reg(5'h10, v); check("result_4x4", v, 32'h10);
        access(1'b0, 1'b0, 1'b1, 5'h00, 16'd9, "cs0_write");
        access(1'b0, 1'b1, 1'b0, 5'h0C, '0, "cs0_read_hold");
        check("cs0_read_dout", d_out, 32'h10);
        wr_reg(5'h08, 16'h0001);
        wait_done(nb);
        rd_reg(5'h10, v); check("cs0_write_ignored", v, 32'h10);

        // Simultaneous read and START write on one edge
        access(1'b1, 1'b1, 1'b1, 5'h08, 16'h0001, "rd_wr_same_edge");
        wait_done(nb);
        check("rd_wr_latency", 32'(nb), 32'(W));

        // Random bus traffic against the model
        for (int it = 0; it < 40; it++) begin
            logic [4:0] ra;
            start_op(W'($urandom), W'($urandom));
            for (int s = 0; s < int'($urandom_range(0, 24)); s++) begin
                case ($urandom_range(0, 6))
                    0: begin
                        ra = ($urandom_range(0, 1) == 0) ? 5'h0C : 5'h10;
                        access(1'b1, 1'b1, 1'b0, ra, '0, "rand_read");
                    end
                    1: wr_reg(5'h00, W'($urandom));
                    2: wr_reg(5'h04, W'($urandom));
                    3: wr_reg(5'h08, W'($urandom));
                    4: access(1'b0, 1'($urandom), 1'($urandom), 5'($urandom), W'($urandom), "rand_cs0");
                    5: access(1'b1, 1'b1, 1'b1, 5'($urandom), W'($urandom), "rand_rdwr");
                    default: idle(1);
                endcase
            end
            wait_done(nb);
            access(1'b1, 1'b1, 1'b0, 5'h10, '0, "rand_result");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
